// File: rtl/eth_pause_pkg.sv
// Shared constants, state type and helpers for the receive-side PAUSE parser.
package eth_pause_pkg;

  localparam logic [47:0] PAUSE_MCAST_DA   = 48'h0180C2000001;
  localparam logic [15:0] ETH_TYPE_MACCTRL = 16'h8808;
  localparam logic [15:0] OPCODE_PAUSE     = 16'h0001;
  localparam int unsigned MIN_FRAME_BYTES  = 64;
  localparam int unsigned PAUSE_W          = 16;
  localparam int unsigned BYTE_CNT_W       = 7;

  typedef enum logic [1:0] {IDLE, HDR, TAIL, SKIP} rx_state_e;

  // Byte idx (0 = first on the wire, MSB) of a 48-bit address.
  function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
    logic [7:0] b;
    b = addr[7:0];
    case (idx)
      3'd0:    b = addr[47:40];
      3'd1:    b = addr[39:32];
      3'd2:    b = addr[31:24];
      3'd3:    b = addr[23:16];
      3'd4:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_rxpausecontrol_if.sv
// Receive byte-stream bundle from the MII-to-byte assembler.
interface eth_rxpausecontrol_if;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxStartFrm;
  logic       RxEndFrm;
  logic       RxCrcError;

  modport master (output RxData, RxValid, RxStartFrm, RxEndFrm, RxCrcError);
  modport slave  (input  RxData, RxValid, RxStartFrm, RxEndFrm, RxCrcError);
endinterface

// File: rtl/eth_pausetimer.sv
// Pause-quanta prescaler and 16-bit saturating down-counter.
module eth_pausetimer
  import eth_pause_pkg::*;
#(
  parameter int unsigned QUANTA_CLKS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PAUSE_W-1:0] load_value,
  input  logic               flow_en,
  output logic [PAUSE_W-1:0] timer
);

  localparam int unsigned PW = (QUANTA_CLKS > 1) ? $clog2(QUANTA_CLKS) : 1;

  logic [PW-1:0] presc;

  // Flow disable clears, load overrides a pending decrement, otherwise count quanta down to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      presc <= '0;
    end else if (!flow_en) begin
      timer <= '0;
      presc <= '0;
    end else if (load) begin
      timer <= load_value;
      presc <= '0;
    end else if (timer != '0) begin
      if (presc == PW'(QUANTA_CLKS - 1)) begin
        timer <= timer - PAUSE_W'(1);
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/eth_rxpausecontrol.sv
// Receive flow control: parses 802.3x PAUSE frames and holds the transmitter off.
module eth_rxpausecontrol
  import eth_pause_pkg::*;
#(
  parameter int unsigned QUANTA_CLKS = 64
) (
  input  logic                       MRxClk,
  input  logic                       RxReset,
  eth_rxpausecontrol_if.slave        rx,
  input  logic [47:0]                MAC,
  input  logic                       r_RxFlow,
  input  logic                       r_PassAll,
  output logic                       TxPause,
  output logic [PAUSE_W-1:0]         PauseTimer,
  output logic                       ReceivedPauseFrm,
  output logic                       DiscardCtrlFrm
);

  rx_state_e               state;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic                    mc_ok;
  logic                    uc_ok;
  logic [PAUSE_W-1:0]      pause_val;

  logic       start_c;
  logic       end_c;
  logic [2:0] da_idx_c;
  logic       mc_hit_c;
  logic       uc_hit_c;
  logic       len_ok_c;
  logic       accept_c;

  // Qualified strobes, DA match flags and the accept decision for this byte.
  always_comb begin
    start_c  = rx.RxValid & rx.RxStartFrm;
    end_c    = rx.RxValid & rx.RxEndFrm;
    da_idx_c = start_c ? 3'd0 : byte_cnt[2:0];
    mc_hit_c = (start_c | mc_ok) & (rx.RxData == addr_byte(PAUSE_MCAST_DA, da_idx_c));
    uc_hit_c = (start_c | uc_ok) & (rx.RxData == addr_byte(MAC, da_idx_c));
    len_ok_c = (({1'b0, byte_cnt} + 8'd1) >= 8'(MIN_FRAME_BYTES));
    accept_c = end_c & ~start_c & (state == TAIL) & len_ok_c & ~rx.RxCrcError;
  end

  // Byte counter: start byte is byte 0, so it leaves the counter at 1; saturates at 127.
  always_ff @(posedge MRxClk) begin
    if (RxReset) begin
      byte_cnt <= '0;
    end else if (start_c) begin
      byte_cnt <= BYTE_CNT_W'(1);
    end else if (rx.RxValid && byte_cnt != '1) begin
      byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
    end
  end

  // Header parser: DA, type, opcode and pause value capture; any mismatch skips the frame.
  always_ff @(posedge MRxClk) begin
    if (RxReset) begin
      state     <= IDLE;
      mc_ok     <= 1'b0;
      uc_ok     <= 1'b0;
      pause_val <= '0;
    end else if (start_c) begin
      mc_ok <= mc_hit_c;
      uc_ok <= uc_hit_c;
      if (end_c)                     state <= IDLE;
      else if (mc_hit_c || uc_hit_c) state <= HDR;
      else                           state <= SKIP;
    end else if (rx.RxValid) begin
      case (state)
        HDR: begin
          if (end_c) begin
            state <= IDLE;
          end else if (byte_cnt <= BYTE_CNT_W'(5)) begin
            mc_ok <= mc_hit_c;
            uc_ok <= uc_hit_c;
            if (!mc_hit_c && !uc_hit_c) state <= SKIP;
          end else begin
            case (byte_cnt)
              BYTE_CNT_W'(12): if (rx.RxData != ETH_TYPE_MACCTRL[15:8]) state <= SKIP;
              BYTE_CNT_W'(13): if (rx.RxData != ETH_TYPE_MACCTRL[7:0])  state <= SKIP;
              BYTE_CNT_W'(14): if (rx.RxData != OPCODE_PAUSE[15:8])     state <= SKIP;
              BYTE_CNT_W'(15): if (rx.RxData != OPCODE_PAUSE[7:0])      state <= SKIP;
              BYTE_CNT_W'(16): pause_val[15:8] <= rx.RxData;
              BYTE_CNT_W'(17): begin
                pause_val[7:0] <= rx.RxData;
                state          <= TAIL;
              end
              default: ;
            endcase
          end
        end
        TAIL, SKIP: if (end_c) state <= IDLE;
        default: ;
      endcase
    end
  end

  // Accept pulses and the registered transmit hold-off.
  always_ff @(posedge MRxClk) begin
    if (RxReset) begin
      ReceivedPauseFrm <= 1'b0;
      DiscardCtrlFrm   <= 1'b0;
      TxPause          <= 1'b0;
    end else begin
      ReceivedPauseFrm <= accept_c;
      DiscardCtrlFrm   <= accept_c & ~r_PassAll;
      TxPause          <= r_RxFlow & (PauseTimer != '0);
    end
  end

  eth_pausetimer #(
    .QUANTA_CLKS (QUANTA_CLKS)
  ) u_timer (
    .clk        (MRxClk),
    .rst        (RxReset),
    .load       (accept_c),
    .load_value (pause_val),
    .flow_en    (r_RxFlow),
    .timer      (PauseTimer)
  );

endmodule

// File: tb/tb_eth_rxpausecontrol.sv
// Directed bench for eth_rxpausecontrol with a frame-level reference model.
module tb_eth_rxpausecontrol;

  localparam int QUANTA = 64;
  localparam logic [47:0] MCAST = 48'h0180C2000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] mac;
  logic        flow;
  logic        passall;
  logic        tx_pause;
  logic [15:0] pause_timer;
  logic        rcv_pulse;
  logic        discard;

  int n_vec = 0;
  int n_err = 0;

  eth_rxpausecontrol_if rx ();

  eth_rxpausecontrol #(.QUANTA_CLKS(QUANTA)) dut (
    .MRxClk           (clk),
    .RxReset          (rst),
    .rx               (rx),
    .MAC              (mac),
    .r_RxFlow         (flow),
    .r_PassAll        (passall),
    .TxPause          (tx_pause),
    .PauseTimer       (pause_timer),
    .ReceivedPauseFrm (rcv_pulse),
    .DiscardCtrlFrm   (discard)
  );

  always #5 clk = ~clk;

  // Reference model: whole-frame acceptance plus remaining pause time in clock cycles.
  logic [7:0]  fq[$];
  bit          in_frame = 0;
  int          rem = 0;
  bit          live = 0;
  logic        e_pulse, e_disc, e_tx;
  logic [15:0] e_timer;

  initial begin
    bit          acc;
    logic [15:0] val;
    logic [47:0] da;
    forever begin
      @(posedge clk);
      if (rst) begin
        fq.delete(); in_frame = 0; rem = 0;
        e_pulse = 0; e_disc = 0; e_tx = 0; e_timer = 16'd0;
      end else begin
        acc = 0; val = 16'd0;
        if (rx.RxValid) begin
          if (rx.RxStartFrm) begin fq.delete(); in_frame = 1; end
          if (in_frame) begin
            fq.push_back(rx.RxData);
            if (rx.RxEndFrm) begin
              in_frame = 0;
              if (fq.size() >= 64 && !rx.RxCrcError) begin
                da  = {fq[0], fq[1], fq[2], fq[3], fq[4], fq[5]};
                val = {fq[16], fq[17]};
                acc = (da == MCAST || da == mac) && fq[12] == 8'h88 && fq[13] == 8'h08
                      && fq[14] == 8'h00 && fq[15] == 8'h01;
              end
            end
          end
        end
        e_tx    = flow && (e_timer != 16'd0);
        e_pulse = acc;
        e_disc  = acc && !passall;
        if (!flow)          rem = 0;
        else if (acc)       rem = int'(val) * QUANTA;
        else if (rem > 0)   rem = rem - 1;
        e_timer = 16'((rem + QUANTA - 1) / QUANTA);
      end
      live = 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      n_vec += 4;
      if (rcv_pulse !== e_pulse) begin n_err++; $display("FAIL cyc pulse t=%0t got=%b exp=%b", $time, rcv_pulse, e_pulse); end
      if (discard !== e_disc) begin n_err++; $display("FAIL cyc discard t=%0t got=%b exp=%b", $time, discard, e_disc); end
      if (tx_pause !== e_tx) begin n_err++; $display("FAIL cyc txpause t=%0t got=%b exp=%b", $time, tx_pause, e_tx); end
      if (pause_timer !== e_timer) begin n_err++; $display("FAIL cyc timer t=%0t got=%h exp=%h", $time, pause_timer, e_timer); end
    end
  end

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] fbyte(input logic [47:0] da, input logic [15:0] et,
                                       input logic [15:0] op, input logic [15:0] v, input int i);
    logic [7:0] b;
    if (i < 6)        b = 8'(da >> (8 * (5 - i)));
    else if (i < 12)  b = 8'(8'h20 + i);
    else if (i == 12) b = et[15:8];
    else if (i == 13) b = et[7:0];
    else if (i == 14) b = op[15:8];
    else if (i == 15) b = op[7:0];
    else if (i == 16) b = v[15:8];
    else if (i == 17) b = v[7:0];
    else              b = 8'(i);
    return b;
  endfunction

  // Sends one frame; returns #1 after the edge that samples the end byte.
  task automatic send_frame(input logic [47:0] da, input logic [15:0] et, input logic [15:0] op,
                            input logic [15:0] v, input int len, input bit crc,
                            input int rst_at, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && (i % 7) == 3) begin
        @(posedge clk); #1;
        rst = 0; rx.RxValid = 0; rx.RxStartFrm = 0; rx.RxEndFrm = 0; rx.RxData = 8'hEE;
      end
      @(posedge clk); #1;
      rst           = (i == rst_at);
      rx.RxValid    = 1;
      rx.RxData     = fbyte(da, et, op, v, i);
      rx.RxStartFrm = (i == 0);
      rx.RxEndFrm   = (i == len - 1);
      rx.RxCrcError = crc && (i == len - 1);
    end
    @(posedge clk); #1;
    rst = 0; rx.RxValid = 0; rx.RxStartFrm = 0; rx.RxEndFrm = 0; rx.RxCrcError = 0;
  endtask

  initial begin
    int cnt;
    rst = 1; mac = 48'h001122334455; flow = 1; passall = 0;
    rx.RxValid = 0; rx.RxStartFrm = 0; rx.RxEndFrm = 0; rx.RxCrcError = 0; rx.RxData = 8'h00;
    step(3);
    lit("rst_timer", pause_timer, 16'h0);
    lit("rst_txpause", 16'(tx_pause), 16'h0);
    lit("rst_pulse", 16'(rcv_pulse), 16'h0);
    rst = 0;
    step(2);

    // Multicast PAUSE of 3 quanta.
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0003, 64, 0, -1, 0);
    lit("mc_pulse", 16'(rcv_pulse), 16'h1);
    lit("mc_discard", 16'(discard), 16'h1);
    lit("mc_timer", pause_timer, 16'h0003);
    lit("mc_tx_at_load", 16'(tx_pause), 16'h0);
    step(1);
    lit("mc_tx_rise", 16'(tx_pause), 16'h1);
    lit("mc_pulse_1cyc", 16'(rcv_pulse), 16'h0);
    cnt = 0;
    while (tx_pause && cnt < 2000) begin step(1); cnt++; end
    lit("mc_tx_duration", 16'(cnt), 16'd192);
    lit("mc_timer_end", pause_timer, 16'h0);

    // Unicast DA, control frames passed through.
    passall = 1;
    send_frame(mac, 16'h8808, 16'h0001, 16'h0010, 64, 0, -1, 0);
    lit("uc_pulse", 16'(rcv_pulse), 16'h1);
    lit("uc_discard", 16'(discard), 16'h0);
    lit("uc_timer", pause_timer, 16'h0010);
    send_frame(mac ^ 48'h1, 16'h8808, 16'h0001, 16'h0002, 64, 0, -1, 0);
    lit("uc_wrong_da", 16'(rcv_pulse), 16'h0);

    // Bad frames: none may pulse.
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0001, 64, 1, -1, 0);
    lit("bad_crc", 16'(rcv_pulse), 16'h0);
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0001, 63, 0, -1, 0);
    lit("bad_short63", 16'(rcv_pulse), 16'h0);
    send_frame(MCAST, 16'h8809, 16'h0001, 16'h0001, 64, 0, -1, 0);
    lit("bad_type", 16'(rcv_pulse), 16'h0);
    send_frame(MCAST, 16'h8808, 16'h0002, 16'h0001, 64, 0, -1, 0);
    lit("bad_opcode", 16'(rcv_pulse), 16'h0);
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0001, 16, 0, -1, 0);
    lit("bad_end15", 16'(rcv_pulse), 16'h0);
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0002, 70, 0, -1, 1);
    lit("gaps_pulse", 16'(rcv_pulse), 16'h1);
    lit("gaps_timer", pause_timer, 16'h0002);

    // Reload with 0 cancels, reload with 5 restarts the quantum.
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0100, 64, 0, -1, 0);
    step(10);
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0000, 64, 0, -1, 0);
    lit("cancel_timer", pause_timer, 16'h0);
    lit("cancel_tx_hold", 16'(tx_pause), 16'h1);
    step(1);
    lit("cancel_tx_low", 16'(tx_pause), 16'h0);
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0100, 64, 0, -1, 0);
    step(7);
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0005, 64, 0, -1, 0);
    lit("reload5_timer", pause_timer, 16'h0005);
    step(63);
    lit("reload5_q63", pause_timer, 16'h0005);
    step(1);
    lit("reload5_q64", pause_timer, 16'h0004);

    // Flow disabled: pulse fires, timer forced 0.
    flow = 0;
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0004, 64, 0, -1, 0);
    lit("noflow_pulse", 16'(rcv_pulse), 16'h1);
    lit("noflow_timer", pause_timer, 16'h0);
    lit("noflow_tx", 16'(tx_pause), 16'h0);
    flow = 1;
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0020, 64, 0, -1, 0);
    step(3);
    lit("midpause_tx", 16'(tx_pause), 16'h1);
    flow = 0;
    step(1);
    lit("flowoff_tx", 16'(tx_pause), 16'h0);
    lit("flowoff_timer", pause_timer, 16'h0);
    flow = 1;

    // Reset at byte 10 during a running pause, then a good frame.
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0010, 64, 0, -1, 0);
    step(2);
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0009, 64, 0, 10, 0);
    lit("rst_mid_pulse", 16'(rcv_pulse), 16'h0);
    lit("rst_mid_timer", pause_timer, 16'h0);
    lit("rst_mid_tx", 16'(tx_pause), 16'h0);
    step(2);
    send_frame(MCAST, 16'h8808, 16'h0001, 16'h0007, 64, 0, -1, 0);
    lit("post_rst_pulse", 16'(rcv_pulse), 16'h1);
    lit("post_rst_timer", pause_timer, 16'h0007);
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
